bus_hold_arbiter: RTL and testbench

CPU-side responder for the DMA hold handshake. Accepts `holdreq` from the DMA controller and lets any CPU bus cycle already in progress finish. It then asserts `holdack`, takes the CPU off the shared data/address bus, and after a settle delay raises `hRDY` to open the DMA transfer window. On `holdreq` deassertion it closes the window in order (`hRDY` low first, then `holdack`) and returns the bus to the CPU. It sits between the CPU bus interface and the DMA block, and drives the DMA block's `holdack`/`hRDY` inputs.

---
 rtl/bus_hold_arbiter_if.sv | 30 +++
 rtl/bus_hold_arbiter.sv | 132 +++++++++++++
 tb/tb_bus_hold_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_hold_arbiter_if.sv
// bus_hold_arbiter_if: DMA hold handshake and CPU bus-control signals.
//   holdreq          DMA -> arbiter    bus hold request (level)
//   cpu_cycle_active CPU -> arbiter    CPU is mid bus cycle
//   holdack          arbiter -> DMA    hold acknowledge
//   hRDY             arbiter -> DMA    transfer window open
//   cpu_bus_en       arbiter -> CPU    CPU may drive the shared bus
//   cpu_stall        arbiter -> CPU    CPU must not start a new bus cycle
//   hold_cycles      arbiter -> status HOLD cycles in current/last grant
//   timeout_irq      arbiter -> CPU    forced-release pulse
// slave modport is the arbiter side, master the DMA/CPU side.
interface bus_hold_arbiter_if;
  logic        holdreq;
  logic        cpu_cycle_active;
  logic        holdack;
  logic        hRDY;
  logic        cpu_bus_en;
  logic        cpu_stall;
  logic [15:0] hold_cycles;
  logic        timeout_irq;

  modport slave (
    input  holdreq, cpu_cycle_active,
    output holdack, hRDY, cpu_bus_en, cpu_stall, hold_cycles, timeout_irq
  );

  modport master (
    output holdreq, cpu_cycle_active,
    input  holdack, hRDY, cpu_bus_en, cpu_stall, hold_cycles, timeout_irq
  );
endinterface

// File: rtl/bus_hold_arbiter.sv
// bus_hold_arbiter: CPU-side responder for the DMA hold handshake.
// Lets an in-flight CPU bus cycle finish, acknowledges the hold, takes the
// CPU off the shared bus, opens the DMA window after a settle delay and
// closes it in order (hRDY first, then holdack) when the request drops.
// Ports:
//   clk  bus clock, rising edge
//   rst  asynchronous active-high reset
//   bus  bus_hold_arbiter_if.slave (holdreq, cpu_cycle_active in;
//        holdack, hRDY, cpu_bus_en, cpu_stall, hold_cycles, timeout_irq out)
// Parameters:
//   SETTLE_CYCLES   holdack-to-hRDY delay, 1..15
//   TIMEOUT_CYCLES  HOLD length forcing release (HOLD_TIMEOUT_EN only)
// Build option: define HOLD_TIMEOUT_EN to enable forced release, the
// timeout_irq pulse and the post-timeout request lockout.
module bus_hold_arbiter #(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  bus_hold_arbiter_if.slave bus
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("bus_hold_arbiter: parameter out of range");
  end

  // S_FAIR is the first IDLE cycle after a release: CPU-owned outputs,
  // but holdreq is not looked at, guaranteeing the CPU a free cycle.
  typedef enum logic [2:0] {
    S_IDLE, S_FAIR, S_DRAIN, S_GRANT, S_HOLD, S_RELEASE
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  settle_cnt;
  logic [15:0] hold_cnt;
  logic        req_ok;
  logic        hold_expired;

`ifdef HOLD_TIMEOUT_EN
  logic lockout;
  logic forced;

  assign hold_expired = (hold_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign req_ok       = bus.holdreq & ~lockout;

  // Lockout is set by a forced release and cleared by any edge that
  // samples holdreq low, so the DMA must drop and re-raise its request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lockout <= 1'b0;
      forced  <= 1'b0;
    end else begin
      forced <= (state == S_HOLD) && bus.holdreq && hold_expired;
      if ((state == S_HOLD) && bus.holdreq && hold_expired)
        lockout <= 1'b1;
      else if (!bus.holdreq)
        lockout <= 1'b0;
    end
  end
`else
  assign hold_expired = 1'b0;
  assign req_ok       = bus.holdreq;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      hold_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if ((state_nxt == S_GRANT) && (state != S_GRANT))
        settle_cnt <= 4'(SETTLE_CYCLES - 1);
      else if ((state == S_GRANT) && (settle_cnt != '0))
        settle_cnt <= settle_cnt - 4'd1;
      if ((state_nxt == S_GRANT) && (state != S_GRANT))
        hold_cnt <= '0;
      else if ((state == S_HOLD) && (hold_cnt != '1))
        hold_cnt <= hold_cnt + 16'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (req_ok) state_nxt = bus.cpu_cycle_active ? S_DRAIN : S_GRANT;
      S_FAIR:    state_nxt = S_IDLE;
      S_DRAIN: begin
        if (!bus.holdreq)               state_nxt = S_IDLE;
        else if (!bus.cpu_cycle_active) state_nxt = S_GRANT;
      end
      S_GRANT: begin
        if (!bus.holdreq)           state_nxt = S_RELEASE;
        else if (settle_cnt == '0)  state_nxt = S_HOLD;
      end
      S_HOLD:    if (!bus.holdreq || hold_expired) state_nxt = S_RELEASE;
      S_RELEASE: state_nxt = S_FAIR;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.holdack     = 1'b0;
    bus.hRDY        = 1'b0;
    bus.cpu_bus_en  = 1'b1;
    bus.cpu_stall   = 1'b0;
    bus.hold_cycles = hold_cnt;
    unique case (state)
      S_DRAIN: bus.cpu_stall = 1'b1;
      S_GRANT, S_RELEASE: begin
        bus.holdack    = 1'b1;
        bus.cpu_bus_en = 1'b0;
        bus.cpu_stall  = 1'b1;
      end
      S_HOLD: begin
        bus.holdack    = 1'b1;
        bus.hRDY       = 1'b1;
        bus.cpu_bus_en = 1'b0;
        bus.cpu_stall  = 1'b1;
      end
      default: ;
    endcase
`ifdef HOLD_TIMEOUT_EN
    bus.timeout_irq = (state == S_RELEASE) && forced;
`else
    bus.timeout_irq = 1'b0;
`endif
  end

endmodule

// File: tb/tb_bus_hold_arbiter.sv
module tb_bus_hold_arbiter;
  localparam int unsigned SETTLE  = 2;
  localparam int unsigned TIMEOUT = 8;
`ifdef HOLD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  bus_hold_arbiter_if bus ();

  bus_hold_arbiter #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: who owns the bus and what the DMA has been told.
  bit          m_ack  = 1'b0;  // DMA has been acknowledged (incl. release cycle)
  bit          m_rdy  = 1'b0;  // transfer window open
  bit          m_wait = 1'b0;  // waiting for the CPU cycle to finish
  bit          m_rel  = 1'b0;  // in the one-cycle ordered release
  bit          m_irq  = 1'b0;
  bit          m_lock = 1'b0;
  int          m_settle = 0;
  int          m_cool   = 0;   // cycles for which holdreq is ignored
  int unsigned m_hc     = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ack = 0; m_rdy = 0; m_wait = 0; m_rel = 0; m_irq = 0; m_lock = 0;
      m_settle = 0; m_cool = 0; m_hc = 0;
    end else begin
      automatic bit req  = bus.holdreq;
      automatic bit busy = bus.cpu_cycle_active;
      automatic bit grant = 1'b0;
      m_irq = 0;
      if (m_rel) begin
        m_rel = 0; m_ack = 0; m_cool = 1;
      end else if (m_rdy) begin
        if (m_hc < 65535) m_hc++;
        if (!req || (TO_EN && m_hc == TIMEOUT)) begin
          m_irq = req;
          if (req) m_lock = 1;
          m_rdy = 0; m_rel = 1;
        end
      end else if (m_ack) begin
        if (!req) m_rel = 1;
        else if (m_settle == 0) m_rdy = 1;
        else m_settle--;
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (m_wait) begin
        if (!req) m_wait = 0;
        else if (!busy) begin m_wait = 0; grant = 1; end
      end else if (req && !m_lock) begin
        if (busy) m_wait = 1; else grant = 1;
      end
      if (grant) begin
        m_ack = 1; m_settle = SETTLE - 1; m_hc = 0;
      end
      if (!req) m_lock = 0;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model, plus the two output invariants.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_holdack",  16'(bus.holdack),    16'(m_ack));
      chk("m_hRDY",     16'(bus.hRDY),       16'(m_rdy));
      chk("m_bus_en",   16'(bus.cpu_bus_en), 16'(!m_ack));
      chk("m_stall",    16'(bus.cpu_stall),  16'(m_ack || m_wait));
      chk("m_hold_cyc", bus.hold_cycles,     16'(m_hc));
      chk("m_irq",      16'(bus.timeout_irq), 16'(m_irq));
      chk("inv_busen_ack", 16'(bus.cpu_bus_en & bus.holdack), 16'd0);
      chk("inv_rdy_ack",   16'(bus.hRDY & ~bus.holdack),      16'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bus.holdreq = 1'b0;
    bus.cpu_cycle_active = 1'b0;

    // Reset values
    #2;
    chk("rst_holdack", 16'(bus.holdack), 16'd0);
    chk("rst_hRDY", 16'(bus.hRDY), 16'd0);
    chk("rst_bus_en", 16'(bus.cpu_bus_en), 16'd1);
    chk("rst_stall", 16'(bus.cpu_stall), 16'd0);
    chk("rst_hold_cyc", bus.hold_cycles, 16'd0);
    chk("rst_irq", 16'(bus.timeout_irq), 16'd0);
    ticks(2);
    rst = 1'b0;
    ticks(2);

    // Idle grant: request sampled at edge A
    bus.holdreq = 1'b1;
    tick();                                            // edge A
    chk("grant_ack_A", 16'(bus.holdack), 16'd1);
    chk("grant_rdy_A", 16'(bus.hRDY), 16'd0);
    chk("grant_busen_A", 16'(bus.cpu_bus_en), 16'd0);
    tick();                                            // A+1
    chk("grant_rdy_A1", 16'(bus.hRDY), 16'd0);
    tick();                                            // A+2
    chk("grant_rdy_A2", 16'(bus.hRDY), 16'd1);
    ticks(4);                                          // A+3..A+6
    bus.holdreq = 1'b0;
    tick();                                            // A+7: 5th HOLD cycle ends
    chk("rel_rdy", 16'(bus.hRDY), 16'd0);
    chk("rel_ack", 16'(bus.holdack), 16'd1);
    chk("rel_hold_cyc", bus.hold_cycles, 16'd5);
    tick();
    chk("rel_ack_low", 16'(bus.holdack), 16'd0);
    chk("rel_busen", 16'(bus.cpu_bus_en), 16'd1);
    chk("rel_stall", 16'(bus.cpu_stall), 16'd0);
    chk("keep_hold_cyc", bus.hold_cycles, 16'd5);
    ticks(3);

    // Drain: CPU busy for 3 cycles after the request
    bus.holdreq = 1'b1;
    bus.cpu_cycle_active = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain_stall", 16'(bus.cpu_stall), 16'd1);
      chk("drain_noack", 16'(bus.holdack), 16'd0);
    end
    bus.cpu_cycle_active = 1'b0;
    tick();
    chk("drain_grant", 16'(bus.holdack), 16'd1);
    chk("drain_hold_cyc_clr", bus.hold_cycles, 16'd0);
    bus.holdreq = 1'b0;
    ticks(4);

    // Abort during drain
    bus.holdreq = 1'b1;
    bus.cpu_cycle_active = 1'b1;
    ticks(2);
    bus.holdreq = 1'b0;
    tick();
    chk("abort_ack", 16'(bus.holdack), 16'd0);
    chk("abort_stall", 16'(bus.cpu_stall), 16'd0);
    bus.cpu_cycle_active = 1'b0;
    ticks(2);

    // Back-to-back: request low for a single edge
    bus.holdreq = 1'b1;
    ticks(5);
    bus.holdreq = 1'b0;
    tick();                                            // -> release
    bus.holdreq = 1'b1;
    tick();                                            // -> fairness cycle
    chk("b2b_fair_ack", 16'(bus.holdack), 16'd0);
    chk("b2b_fair_busen", 16'(bus.cpu_bus_en), 16'd1);
    chk("b2b_fair_stall", 16'(bus.cpu_stall), 16'd0);
    tick();                                            // request ignored
    chk("b2b_idle_ack", 16'(bus.holdack), 16'd0);
    tick();
    chk("b2b_regrant", 16'(bus.holdack), 16'd1);
    ticks(4);

    // Asynchronous reset mid-HOLD
    chk("pre_rst_rdy", 16'(bus.hRDY), 16'd1);
    #3 rst = 1'b1;
    #1;
    chk("arst_ack", 16'(bus.holdack), 16'd0);
    chk("arst_rdy", 16'(bus.hRDY), 16'd0);
    chk("arst_busen", 16'(bus.cpu_bus_en), 16'd1);
    chk("arst_hold_cyc", bus.hold_cycles, 16'd0);
    bus.holdreq = 1'b0;
    ticks(2);
    rst = 1'b0;
    ticks(2);

`ifdef HOLD_TIMEOUT_EN
    // Forced release after TIMEOUT HOLD cycles with holdreq held high
    bus.holdreq = 1'b1;
    tick();                                            // edge A
    ticks(2);                                          // A+2: HOLD
    ticks(7);                                          // A+9
    chk("to_before", 16'(bus.timeout_irq), 16'd0);
    tick();                                            // A+10
    chk("to_irq", 16'(bus.timeout_irq), 16'd1);
    chk("to_rdy", 16'(bus.hRDY), 16'd0);
    chk("to_hold_cyc", bus.hold_cycles, 16'd8);
    tick();
    chk("to_irq_pulse", 16'(bus.timeout_irq), 16'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("to_lockout", 16'(bus.holdack), 16'd0);
    end
    bus.holdreq = 1'b0;
    tick();
    bus.holdreq = 1'b1;
    tick();
    chk("to_regrant", 16'(bus.holdack), 16'd1);
    bus.holdreq = 1'b0;
    ticks(4);
`else
    // Without the timeout build HOLD persists
    bus.holdreq = 1'b1;
    ticks(3 + 20);
    chk("noto_hold", 16'(bus.hRDY), 16'd1);
    chk("noto_hold_cyc", bus.hold_cycles, 16'd20);
    bus.holdreq = 1'b0;
    ticks(4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
